rv32_execute_seq: RTL and testbench
===================================

Name: rv32_execute_seq

Overview:
Upstream sequencer for the multicycle 16-bit-slice ALU (rv32_alu_fsm). It accepts one decoded ALU instruction per valid/ready handshake and latches its operands. It resets the ALU slice counter, drives the ALU for its low-half and high-half cycles, then captures the 32-bit result. It presents the result to register-file writeback over a valid/ready handshake.

Parameters:
MAX_WAIT, 4, cycles allowed in EXEC_HI for i_alu_valid before timeout (>=1)
RD_W, 5, destination register index width

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_instr_valid  in  1  decoded instruction valid
o_instr_ready  out  1  sequencer can accept an instruction
i_alu_op  in  2  00 ADD, 01 AND, 10 OR, 11 XOR
i_rs1_data  in  32  source operand 1
i_rs2_data  in  32  source operand 2
i_imm  in  32  sign-extended immediate
i_use_imm  in  1  operand two = i_imm instead of i_rs2_data
i_rd  in  RD_W  destination register
o_alu_rst  out  1  reset of the ALU slice counter
o_alu_en  out  1  ALU enable
o_alu_sel  out  2  ALU select, equals latched op
o_alu_op_one  out  32  latched operand one
o_alu_op_two  out  32  latched operand two
i_alu_valid  in  1  ALU result valid (combinational, high-half cycle)
i_alu_result  in  32  ALU result
i_alu_carry  in  1  ALU carry out
o_wb_valid  out  1  writeback valid
i_wb_ready  in  1  writeback accepted
o_wb_rd  out  RD_W  writeback register
o_wb_data  out  32  writeback data
o_wb_carry  out  1  carry of last ADD (0 for logic ops)
o_exec_err  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- States: IDLE, CLR, EXEC_LO, EXEC_HI, WB.
- Reset values: state=IDLE, o_instr_ready=1, o_wb_valid=0, o_exec_err=0, o_alu_en=0, o_wb_data/o_wb_rd/o_wb_carry/latched operands=0.
- o_alu_rst = i_rst OR state==CLR.
- o_instr_ready = (state==IDLE). It is never high in any other state.
- IDLE: on i_instr_valid&o_instr_ready, latch op, rs1, (i_use_imm ? i_imm : i_rs2_data), and rd, then go to CLR.
- CLR: o_alu_en=0; the ALU slice counter is cleared at this edge. Go to EXEC_LO.
- EXEC_LO: o_alu_en=1 and the low half is computed. Go to EXEC_HI.
- EXEC_HI: o_alu_en=0, which holds the ALU counter on the high-half phase.
  - On i_alu_valid: capture i_alu_result into o_wb_data. Capture i_alu_carry into o_wb_carry only if op==ADD, else 0. Go to WB, or to IDLE if rd==0 (x0 writes are discarded).
  - Otherwise increment the wait counter. When the counter reaches MAX_WAIT, set o_exec_err, discard the result, and go to IDLE.
- WB: o_wb_valid=1, with o_wb_data/o_wb_rd/o_wb_carry stable while valid and not ready. On i_wb_ready, go to IDLE.
- Latency: accept at edge N, o_wb_valid high in cycle N+4. Sustained throughput is 1 instruction per 5 cycles with i_wb_ready held high.
- o_alu_sel/op_one/op_two are stable from CLR through EXEC_HI. They may change only on acceptance in IDLE.
- o_exec_err is cleared only by i_rst.
- Reset mid-operation: unconditional return to IDLE. Any pending writeback is dropped and o_wb_valid is low in the next cycle.
- i_instr_valid outside IDLE is ignored; the upstream stage must hold it.

Optional Feature:
- Macro EXEC_SEQ_PERF_CNT_EN. When defined, adds output o_retired_cnt (32 bits).
  - It increments on each completed instruction: WB handshake, or rd==0 completion in EXEC_HI.
  - It wraps 0xFFFFFFFF->0 and is reset to 0.
- Without the macro, the port exists and is tied to 0.

Decomposition:
- Package rv32_exec_pkg holds:
  - alu_op_e: ALU_ADD=2'b00, ALU_AND=2'b01, ALU_OR=2'b10, ALU_XOR=2'b11.
  - exec_state_e.
  - RV_XLEN=32.
- Natural sub-module: rv32_event_counter, a wrapping counter with enable, used for both the wait counter and the perf counter.

Test Plan:
- ADD rs1=0x0000FFFF rs2=0x00000001 rd=3, wb_ready=1 -> o_wb_valid at accept+4 with data 0x00010000, rd=3, carry=0.
- ADD rs1=0xFFFFFFFF imm=0x00000001 use_imm=1 rd=5 -> data 0x00000000, carry=1; XOR 0xF0F0F0F0^0xFFFF0000 -> 0x0F0FF0F0, carry=0.
- AND with rd=0 -> o_wb_valid never asserted; o_instr_ready back high at accept+4; perf count +1 when enabled.
- OR 0x12340000|0x00005678 with wb_ready=0 for 3 cycles -> o_wb_valid, data 0x12345678 and rd held stable; instr_ready stays low until the handshake.
- Model ALU with i_alu_valid stuck 0 -> o_exec_err=1 after MAX_WAIT=4 EXEC_HI cycles, state IDLE, no writeback; stays set until i_rst.
- Assert i_rst during EXEC_LO and again during WB -> next cycle o_wb_valid=0, o_instr_ready=1, o_alu_rst=1 during reset; the next instruction completes correctly.

Source files
------------

// File: rtl/rv32_exec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_exec_pkg
//  Description : Shared types for the execute sequencer. Holds the ALU
//                opcode encoding, the sequencer state encoding and the
//                machine word width.
//  Revision    : 1.0 - initial release
// ============================================================================
package rv32_exec_pkg;

    localparam int RV_XLEN = 32;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_AND = 2'b01,
        ALU_OR  = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR     = 3'd1,
        ST_EXEC_LO = 3'd2,
        ST_EXEC_HI = 3'd3,
        ST_WB      = 3'd4
    } exec_state_e;

endpackage : rv32_exec_pkg
`default_nettype wire

// File: rtl/rv32_event_counter.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_event_counter
//  Description : Free-running wrapping event counter with synchronous clear
//                and count enable. Reset and clear both force zero; the
//                counter wraps from all-ones back to zero.
//  Ports       : i_clk   - clock
//                i_rst   - synchronous active-high reset
//                i_clr   - synchronous clear (same effect as reset)
//                i_en    - count one event this cycle
//                o_count - current count
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_event_counter #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : rv32_event_counter
`default_nettype wire

// File: rtl/rv32_execute_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rv32_execute_seq
//  Description : Sequencer in front of the multicycle 16-bit-slice ALU.
//                Accepts one decoded instruction per valid/ready handshake,
//                latches its operands, clears the ALU slice counter, runs the
//                low and high halves, captures the 32-bit result and offers it
//                to writeback over a valid/ready handshake.
//                Flow: IDLE -> CLR -> EXEC_LO -> EXEC_HI -> WB -> IDLE.
//  Ports       : i_clk/i_rst               - clock, sync active-high reset
//                i_instr_valid/o_instr_ready, i_alu_op, i_rs1_data,
//                i_rs2_data, i_imm, i_use_imm, i_rd
//                                          - instruction input handshake
//                o_alu_rst, o_alu_en, o_alu_sel, o_alu_op_one, o_alu_op_two,
//                i_alu_valid, i_alu_result, i_alu_carry
//                                          - ALU slice interface
//                o_wb_valid/i_wb_ready, o_wb_rd, o_wb_data, o_wb_carry
//                                          - register-file writeback
//                o_exec_err                - sticky ALU timeout flag
//                o_retired_cnt             - retired instruction count
//  Config      : EXEC_SEQ_PERF_CNT_EN - when defined, o_retired_cnt counts
//                completed instructions; otherwise it is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv32_execute_seq
    import rv32_exec_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int RD_W     = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_instr_valid,
    output logic                 o_instr_ready,
    input  logic [1:0]           i_alu_op,
    input  logic [RV_XLEN-1:0]   i_rs1_data,
    input  logic [RV_XLEN-1:0]   i_rs2_data,
    input  logic [RV_XLEN-1:0]   i_imm,
    input  logic                 i_use_imm,
    input  logic [RD_W-1:0]      i_rd,
    output logic                 o_alu_rst,
    output logic                 o_alu_en,
    output logic [1:0]           o_alu_sel,
    output logic [RV_XLEN-1:0]   o_alu_op_one,
    output logic [RV_XLEN-1:0]   o_alu_op_two,
    input  logic                 i_alu_valid,
    input  logic [RV_XLEN-1:0]   i_alu_result,
    input  logic                 i_alu_carry,
    output logic                 o_wb_valid,
    input  logic                 i_wb_ready,
    output logic [RD_W-1:0]      o_wb_rd,
    output logic [RV_XLEN-1:0]   o_wb_data,
    output logic                 o_wb_carry,
    output logic                 o_exec_err,
    output logic [31:0]          o_retired_cnt
);

    // Wide enough to hold MAX_WAIT itself.
    localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);

    exec_state_e          r_state;
    alu_op_e              r_alu_sel;
    logic [RV_XLEN-1:0]   r_op_one;
    logic [RV_XLEN-1:0]   r_op_two;
    logic [RD_W-1:0]      r_rd;
    logic                 r_alu_en;
    logic                 r_wb_valid;
    logic [RV_XLEN-1:0]   r_wb_data;
    logic                 r_wb_carry;
    logic                 r_exec_err;

    logic [c_WAIT_W-1:0]  w_wait_cnt;
    logic                 w_wait_clr;
    logic                 w_wait_inc;
    logic                 w_wait_last;
    logic                 w_rd_zero;

    assign w_rd_zero   = (r_rd == '0);

    // The wait count restarts with every instruction and advances on each
    // EXEC_HI cycle the ALU has not yet delivered. The cycle whose count is
    // MAX_WAIT-1 is the last allowed one, so exactly MAX_WAIT EXEC_HI cycles
    // are granted before the timeout.
    assign w_wait_clr  = (r_state == ST_CLR);
    assign w_wait_inc  = (r_state == ST_EXEC_HI) && !i_alu_valid;
    assign w_wait_last = (w_wait_cnt == c_WAIT_W'(MAX_WAIT - 1));

    rv32_event_counter #(
        .WIDTH (c_WAIT_W)
    ) u_wait_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (w_wait_clr),
        .i_en    (w_wait_inc),
        .o_count (w_wait_cnt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_alu_sel  <= ALU_ADD;
            r_op_one   <= '0;
            r_op_two   <= '0;
            r_rd       <= '0;
            r_alu_en   <= 1'b0;
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_carry <= 1'b0;
            r_exec_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_instr_valid) begin
                        r_alu_sel <= alu_op_e'(i_alu_op);
                        r_op_one  <= i_rs1_data;
                        r_op_two  <= i_use_imm ? i_imm : i_rs2_data;
                        r_rd      <= i_rd;
                        r_state   <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    // ALU counter is cleared this cycle; enable it next.
                    r_alu_en <= 1'b1;
                    r_state  <= ST_EXEC_LO;
                end
                ST_EXEC_LO: begin
                    // Dropping enable parks the ALU on its high-half slice.
                    r_alu_en <= 1'b0;
                    r_state  <= ST_EXEC_HI;
                end
                ST_EXEC_HI: begin
                    if (i_alu_valid) begin
                        if (w_rd_zero) begin
                            // Writes to x0 retire without a writeback.
                            r_state <= ST_IDLE;
                        end else begin
                            r_wb_data  <= i_alu_result;
                            r_wb_carry <= (r_alu_sel == ALU_ADD) && i_alu_carry;
                            r_wb_valid <= 1'b1;
                            r_state    <= ST_WB;
                        end
                    end else if (w_wait_last) begin
                        r_exec_err <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_WB: begin
                    if (i_wb_ready) begin
                        r_wb_valid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_instr_ready = (r_state == ST_IDLE);
    assign o_alu_rst     = i_rst || (r_state == ST_CLR);
    assign o_alu_en      = r_alu_en;
    assign o_alu_sel     = r_alu_sel;
    assign o_alu_op_one  = r_op_one;
    assign o_alu_op_two  = r_op_two;
    assign o_wb_valid    = r_wb_valid;
    assign o_wb_rd       = r_rd;
    assign o_wb_data     = r_wb_data;
    assign o_wb_carry    = r_wb_carry;
    assign o_exec_err    = r_exec_err;

`ifdef EXEC_SEQ_PERF_CNT_EN
    // An instruction retires on the writeback handshake or, for rd == x0,
    // when the ALU delivers in EXEC_HI. Timeouts do not retire.
    logic w_retire;

    assign w_retire = ((r_state == ST_WB) && i_wb_ready) ||
                      ((r_state == ST_EXEC_HI) && i_alu_valid && w_rd_zero);

    rv32_event_counter #(
        .WIDTH (32)
    ) u_perf_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clr   (1'b0),
        .i_en    (w_retire),
        .o_count (o_retired_cnt)
    );
`else
    assign o_retired_cnt = '0;
`endif

endmodule : rv32_execute_seq
`default_nettype wire

// File: tb/tb_rv32_execute_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv32_execute_seq
//  Description : Self-checking bench for rv32_execute_seq. A behavioural ALU
//                stub answers the sequencer; a transaction-level reference
//                predicts result, carry, completion cycle, error and retire
//                count for each instruction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32_execute_seq;
    import rv32_exec_pkg::*;

    localparam int MAX_WAIT = 4;
    localparam int RD_W     = 5;
`ifdef EXEC_SEQ_PERF_CNT_EN
    localparam bit c_PERF_EN = 1'b1;
`else
    localparam bit c_PERF_EN = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              instr_valid;
    logic              instr_ready;
    logic [1:0]        alu_op;
    logic [31:0]       rs1_data, rs2_data, imm;
    logic              use_imm;
    logic [RD_W-1:0]   rd;
    logic              alu_rst, alu_en;
    logic [1:0]        alu_sel;
    logic [31:0]       alu_op_one, alu_op_two;
    logic              alu_valid;
    logic [31:0]       alu_result;
    logic              alu_carry;
    logic              wb_valid, wb_ready;
    logic [RD_W-1:0]   wb_rd;
    logic [31:0]       wb_data;
    logic              wb_carry;
    logic              exec_err;
    logic [31:0]       retired_cnt;

    rv32_execute_seq #(
        .MAX_WAIT (MAX_WAIT),
        .RD_W     (RD_W)
    ) u_dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_instr_valid (instr_valid),
        .o_instr_ready (instr_ready),
        .i_alu_op      (alu_op),
        .i_rs1_data    (rs1_data),
        .i_rs2_data    (rs2_data),
        .i_imm         (imm),
        .i_use_imm     (use_imm),
        .i_rd          (rd),
        .o_alu_rst     (alu_rst),
        .o_alu_en      (alu_en),
        .o_alu_sel     (alu_sel),
        .o_alu_op_one  (alu_op_one),
        .o_alu_op_two  (alu_op_two),
        .i_alu_valid   (alu_valid),
        .i_alu_result  (alu_result),
        .i_alu_carry   (alu_carry),
        .o_wb_valid    (wb_valid),
        .i_wb_ready    (wb_ready),
        .o_wb_rd       (wb_rd),
        .o_wb_data     (wb_data),
        .o_wb_carry    (wb_carry),
        .o_exec_err    (exec_err),
        .o_retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ALU stub --------------------------------------------
    // Slice counter cleared by alu_rst, advanced by alu_en; the result is
    // offered while the counter sits on slice 1, after alu_delay extra
    // cycles, unless alu_stuck is set. Logic ops report a raw carry of
    // a[31]&b[31] so carry gating in the sequencer is exercised.
    logic [1:0] alu_slice;
    int         hi_wait;
    int         alu_delay;
    bit         alu_stuck;

    always @(posedge clk) begin
        if (alu_rst) begin
            alu_slice <= 2'd0;
            hi_wait   <= 0;
        end else begin
            if (alu_en) alu_slice <= alu_slice + 2'd1;
            if (alu_slice == 2'd1) hi_wait <= hi_wait + 1;
        end
    end

    assign alu_valid = !alu_stuck && (alu_slice == 2'd1) && (hi_wait >= alu_delay);

    always_comb begin
        alu_result = 32'd0;
        alu_carry  = alu_op_one[31] & alu_op_two[31];
        case (alu_sel)
            2'b00:   {alu_carry, alu_result} = {1'b0, alu_op_one} + {1'b0, alu_op_two};
            2'b01:   alu_result = alu_op_one & alu_op_two;
            2'b10:   alu_result = alu_op_one | alu_op_two;
            default: alu_result = alu_op_one ^ alu_op_two;
        endcase
    end

    // ---------------- checking infrastructure -----------------------------
    int checks   = 0;
    int failures = 0;
    int model_perf = 0;
    bit model_err  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        use_imm;
        logic [4:0]  rd;
        int          delay;
        int          stall;
        bit          stuck;
        logic [31:0] exp_data;
        logic        exp_carry;
    } vec_t;

    function automatic void ref_alu(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b,
                                    output logic [31:0] d, output logic c);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        c   = 1'b0;
        case (op)
            2'b00:   begin d = sum[31:0]; c = sum[32]; end
            2'b01:   d = a & b;
            2'b10:   d = a | b;
            default: d = a ^ b;
        endcase
    endfunction

    // Entered just after a negedge with the DUT idle; returns the same way.
    task automatic run(input vec_t v);
        bit          tmo;
        bit          wb_exp;
        int          exp_n;
        int          n;
        logic [31:0] opb;
        tmo    = v.stuck || (v.delay >= MAX_WAIT);
        wb_exp = !tmo && (v.rd != 5'd0);
        exp_n  = tmo ? 3 + MAX_WAIT : 4 + v.delay;
        opb    = v.use_imm ? v.imm : v.rs2;

        alu_delay   = v.delay;
        alu_stuck   = v.stuck;
        alu_op      = v.op;
        rs1_data    = v.rs1;
        rs2_data    = v.rs2;
        imm         = v.imm;
        use_imm     = v.use_imm;
        rd          = v.rd;
        instr_valid = 1'b1;
        wb_ready    = (v.stall == 0);
        chk("instr_ready_idle", {31'd0, instr_ready}, 32'd1);

        @(negedge clk);
        // Scramble the inputs after acceptance to prove they were latched.
        instr_valid = 1'b0;
        rs1_data    = $urandom;
        rs2_data    = $urandom;
        imm         = $urandom;
        alu_op      = 2'($urandom_range(0, 3));
        rd          = 5'($urandom_range(0, 31));
        n = 1;
        chk("clr_alu_rst", {31'd0, alu_rst}, 32'd1);
        chk("clr_alu_en", {31'd0, alu_en}, 32'd0);
        chk("op_one", alu_op_one, v.rs1);
        chk("op_two", alu_op_two, opb);
        chk("alu_sel", {30'd0, alu_sel}, {30'd0, v.op});

        @(negedge clk);
        n = 2;
        chk("lo_alu_en", {31'd0, alu_en}, 32'd1);
        chk("lo_instr_ready", {31'd0, instr_ready}, 32'd0);

        while (!(wb_valid || instr_ready) && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("done_cycle", n, exp_n);

        if (wb_exp) begin
            chk("wb_valid", {31'd0, wb_valid}, 32'd1);
            chk("wb_data", wb_data, v.exp_data);
            chk("wb_rd", {27'd0, wb_rd}, {27'd0, v.rd});
            chk("wb_carry", {31'd0, wb_carry}, {31'd0, v.exp_carry});
            for (int s = 0; s < v.stall; s++) begin
                @(negedge clk);
                chk("stall_wb_valid", {31'd0, wb_valid}, 32'd1);
                chk("stall_wb_data", wb_data, v.exp_data);
                chk("stall_wb_rd", {27'd0, wb_rd}, {27'd0, v.rd});
                chk("stall_instr_ready", {31'd0, instr_ready}, 32'd0);
            end
            wb_ready = 1'b1;
            @(negedge clk);
            chk("post_wb_valid", {31'd0, wb_valid}, 32'd0);
            chk("post_wb_ready", {31'd0, instr_ready}, 32'd1);
        end else begin
            chk("nowb_valid", {31'd0, wb_valid}, 32'd0);
            chk("nowb_ready", {31'd0, instr_ready}, 32'd1);
        end

        if (tmo) model_err = 1'b1;
        else     model_perf++;
        chk("exec_err", {31'd0, exec_err}, {31'd0, model_err});
        chk("retired_cnt", retired_cnt, c_PERF_EN ? model_perf : 0);
    endtask

    vec_t tbl[8];
    vec_t rv;
    int   n;

    initial begin
        //       op     rs1           rs2           imm           ui rd  dly st stk exp_data     c
        tbl[0] = '{2'b00, 32'h0000FFFF, 32'h00000001, 32'hDEADBEEF, 0, 3, 0, 0, 0, 32'h00010000, 0};
        tbl[1] = '{2'b00, 32'hFFFFFFFF, 32'h12345678, 32'h00000001, 1, 5, 0, 0, 0, 32'h00000000, 1};
        tbl[2] = '{2'b11, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0, 0, 7, 0, 0, 0, 32'h0F0FF0F0, 0};
        tbl[3] = '{2'b01, 32'hFF00FF00, 32'h0FF00FF0, 32'h0, 0, 0, 0, 0, 0, 32'h0F000F00, 0};
        tbl[4] = '{2'b10, 32'h12340000, 32'h00005678, 32'h0, 0, 9, 0, 3, 0, 32'h12345678, 0};
        tbl[5] = '{2'b00, 32'h7FFFFFFF, 32'h00000001, 32'h0, 0, 31, 2, 0, 0, 32'h80000000, 0};
        tbl[6] = '{2'b00, 32'h11111111, 32'h22222222, 32'h0, 0, 4, 0, 0, 1, 32'h33333333, 0};
        tbl[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h0, 0, 1, 1, 1, 0, 32'h00000000, 1};

        rst = 1'b1; instr_valid = 1'b0; wb_ready = 1'b0;
        alu_op = 2'b00; rs1_data = '0; rs2_data = '0; imm = '0; use_imm = 1'b0; rd = '0;
        alu_delay = 0; alu_stuck = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_instr_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_exec_err", {31'd0, exec_err}, 32'd0);
        chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
        chk("rst_alu_rst", {31'd0, alu_rst}, 32'd1);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
        chk("rst_wb_carry", {31'd0, wb_carry}, 32'd0);
        chk("rst_op_one", alu_op_one, 32'd0);
        chk("rst_op_two", alu_op_two, 32'd0);
        chk("rst_retired", retired_cnt, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_alu_rst", {31'd0, alu_rst}, 32'd0);

        // Directed table (entry 6 times out and leaves exec_err sticky).
        for (int i = 0; i < 8; i++) run(tbl[i]);

        // Reset during EXEC_LO.
        alu_delay = 0; alu_stuck = 1'b0; wb_ready = 1'b1;
        alu_op = 2'b00; rs1_data = 32'h5; rs2_data = 32'h6; use_imm = 1'b0; rd = 5'd3;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("rstlo_alu_en", {31'd0, alu_en}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstlo_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rstlo_instr_ready", {31'd0, instr_ready}, 32'd1);
        chk("rstlo_alu_rst", {31'd0, alu_rst}, 32'd1);
        chk("rstlo_exec_err", {31'd0, exec_err}, 32'd0);
        rst = 1'b0;
        model_err = 1'b0; model_perf = 0;
        @(negedge clk);

        // Reset while a writeback is pending.
        wb_ready = 1'b0;
        alu_op = 2'b10; rs1_data = 32'hA0; rs2_data = 32'h0B; rd = 5'd6;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        n = 0;
        while (!wb_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rstwb_reached_wb", {31'd0, wb_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstwb_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rstwb_instr_ready", {31'd0, instr_ready}, 32'd1);
        chk("rstwb_alu_rst", {31'd0, alu_rst}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Recovery after reset.
        run(tbl[0]);

        // Randomized traffic against the reference.
        for (int i = 0; i < 40; i++) begin
            rv.op      = 2'($urandom_range(0, 3));
            rv.rs1     = $urandom;
            rv.rs2     = $urandom;
            rv.imm     = $urandom;
            rv.use_imm = 1'($urandom_range(0, 1));
            rv.rd      = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            rv.delay   = $urandom_range(0, 5);
            rv.stall   = $urandom_range(0, 2);
            rv.stuck   = 1'b0;
            ref_alu(rv.op, rv.rs1, rv.use_imm ? rv.imm : rv.rs2, rv.exp_data, rv.exp_carry);
            run(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rv32_execute_seq
`default_nettype wire
